// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one external ALU, one operation at a time.
// An accepted operation is latched, presented to the ALU for one cycle, and the
// captured result is then offered to its owner until that owner consumes it.
//
// state | meaning
// IDLE  | no operation in flight; grant offered to a pending requester
// EXEC  | latched operands drive the ALU; result captured at end of cycle
// RESP  | captured result offered to the owner until its rsp ready is seen
module alu_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic [2:0]   req0_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [n-1:0] rsp0_result,
  output logic         rsp0_zero,
  output logic         rsp0_err,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [n-1:0] rsp1_result,
  output logic         rsp1_zero,
  output logic         rsp1_err,

  output logic [n-1:0] SrcA,
  output logic [n-1:0] SrcB,
  output logic [2:0]   ALUControl,
  input  logic [n-1:0] ALUResult,
  input  logic         Zero,

  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state, next_state;
  logic         prio;
  logic         owner;
  logic         grant;
  logic         any_valid;
  logic         accept;
  logic         owner_rsp_ready;
  logic [n-1:0] a_q, b_q, result_q;
  logic [2:0]   op_q;
  logic         zero_q, err_q;

  // Requester that wins if the arbiter is idle: a lone requester, else the priority pointer
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = prio;
    else                          grant = req1_valid;
  end

  assign accept          = (state == IDLE) && any_valid;
  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; EXEC always lasts exactly one cycle
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (any_valid) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (owner_rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs; readys are also forced low while reset is asserted
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != IDLE);
    if (!reset && state == IDLE && any_valid) begin
      req0_ready = ~grant;
      req1_ready = grant;
    end
    if (state == RESP) begin
      rsp0_valid = ~owner;
      rsp1_valid = owner;
    end
  end

  // Operand latch on accept, result capture after EXEC, priority hand-off when the owner consumes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      owner    <= 1'b0;
      prio     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= grant ? req1_a  : req0_a;
        b_q   <= grant ? req1_b  : req0_b;
        op_q  <= grant ? req1_op : req0_op;
        owner <= grant;
      end
      if (state == EXEC) begin
        result_q <= ALUResult;
        zero_q   <= Zero;
        err_q    <= (op_q >= 3'd6);
      end
      if (state == RESP && owner_rsp_ready) prio <= ~owner;
    end
  end

  // The ALU only ever sees latched values, never live request inputs
  assign SrcA       = a_q;
  assign SrcB       = b_q;
  assign ALUControl = op_q;

  // Both response buses share the capture registers; each is qualified by its own valid
  assign rsp0_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_result = result_q;
  assign rsp1_zero   = zero_q;
  assign rsp1_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random transactions against a transaction-level model.
// The bench also plays the shared ALU.
module tb_alu_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [N-1:0] rsp0_result, rsp1_result;
  logic         rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [N-1:0] SrcA, SrcB, ALUResult;
  logic [2:0]   ALUControl;
  logic         Zero;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  int model_prio = 0;

  alu_arbiter #(.n(N)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .ALUResult(ALUResult), .Zero(Zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU: add, sub, and, or, xor, signed set-less-than; codes 6/7 yield 0
  function automatic logic [N-1:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
      default: return '0;
    endcase
  endfunction

  assign ALUResult = alu_ref(SrcA, SrcB, ALUControl);
  assign Zero      = (ALUResult == '0);

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int k, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (k == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic set_rsp_ready(input int k, input logic v);
    if (k == 0) rsp0_ready = v;
    else        rsp1_ready = v;
  endtask

  // One complete transaction: grant, EXEC, RESP held for 'hold' extra cycles, consume
  task automatic run_txn(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                         input int hold, input string tag);
    int           w;
    logic [31:0]  ea, eb, er;
    logic [2:0]   eo;
    w  = (v0 && v1) ? model_prio : (v1 ? 1 : 0);
    ea = (w == 1) ? a1 : a0;
    eb = (w == 1) ? b1 : b0;
    eo = (w == 1) ? op1 : op0;
    er = alu_ref(ea, eb, eo);

    drive_req(0, v0, a0, b0, op0);
    drive_req(1, v1, a1, b1, op1);
    #1;
    check(tag, "ready0", 32'(req0_ready), 32'(w == 0));
    check(tag, "ready1", 32'(req1_ready), 32'(w == 1));
    check(tag, "busy_idle", 32'(busy), 32'(0));
    step();

    // Winner withdraws and scrambles its inputs; the other requester stays pending
    drive_req(w, 1'b0, $urandom, $urandom, 3'($urandom));
    if (w == 0) drive_req(1, 1'b1, a1, b1, op1);
    else        drive_req(0, 1'b1, a0, b0, op0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    check(tag, "busy_exec", 32'(busy), 32'(1));
    check(tag, "rsp_valid_exec", 32'({rsp1_valid, rsp0_valid}), 32'(0));
    check(tag, "ready_exec", 32'({req1_ready, req0_ready}), 32'(0));
    check(tag, "SrcA", SrcA, ea);
    check(tag, "SrcB", SrcB, eb);
    check(tag, "ALUControl", 32'(ALUControl), 32'(eo));
    step();

    for (int i = 0; i <= hold; i++) begin
      set_rsp_ready(w, i == hold);
      set_rsp_ready(1 - w, 1'b1);
      #1;
      check(tag, "rsp_valid_owner", 32'((w == 0) ? rsp0_valid : rsp1_valid), 32'(1));
      check(tag, "rsp_valid_other", 32'((w == 0) ? rsp1_valid : rsp0_valid), 32'(0));
      check(tag, "result", (w == 0) ? rsp0_result : rsp1_result, er);
      check(tag, "zero", 32'((w == 0) ? rsp0_zero : rsp1_zero), 32'(er == 0));
      check(tag, "err", 32'((w == 0) ? rsp0_err : rsp1_err), 32'(eo >= 3'd6));
      check(tag, "busy_resp", 32'(busy), 32'(1));
      check(tag, "ready_resp", 32'({req1_ready, req0_ready}), 32'(0));
      step();
    end
    check(tag, "busy_done", 32'(busy), 32'(0));
    check(tag, "rsp_valid_done", 32'({rsp1_valid, rsp0_valid}), 32'(0));
    model_prio = 1 - w;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  sel;
    logic [31:0] ra0, rb0, ra1, rb1;
    logic [2:0]  rop0, rop1;

    // Reset takes effect before any clock edge
    #1 reset = 1'b1;
    req0_valid = 1'b1;
    #1;
    check("reset", "busy", 32'(busy), 32'(0));
    check("reset", "ready", 32'({req1_ready, req0_ready}), 32'(0));
    check("reset", "rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(0));
    check("reset", "SrcA", SrcA, 32'(0));
    check("reset", "SrcB", SrcB, 32'(0));
    check("reset", "ALUControl", 32'(ALUControl), 32'(0));
    check("reset", "result", rsp0_result, 32'(0));
    req0_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_prio = 0;
    step();
    #1;
    check("idle", "ready", 32'({req1_ready, req0_ready}), 32'(0));
    check("idle", "busy", 32'(busy), 32'(0));
    step();

    run_txn(1'b1, 32'd5, 32'd3, 3'd1, 1'b0, 32'd0, 32'd0, 3'd0, 0, "sub_req0");
    run_txn(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'd7, 32'd7, 3'd1, 0, "zero_req1");
    run_txn(1'b1, 32'd9, 32'd4, 3'd7, 1'b0, 32'd0, 32'd0, 3'd0, 1, "op7_err");
    run_txn(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd5, 1'b0, 32'd0, 32'd0, 3'd0, 0, "slt_neg");
    run_txn(1'b1, 32'h12, 32'h34, 3'd0, 1'b0, 32'h55, 32'h0F, 3'd4, 5, "hold5");
    run_txn(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h55, 32'h0F, 3'd4, 0, "after_hold");

    // Reset pulse in the middle of RESP drops the response without a clock edge
    drive_req(0, 1'b1, 32'd11, 32'd2, 3'd0);
    step();
    drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    step();
    #1;
    check("rst_resp", "valid_before", 32'(rsp0_valid), 32'(1));
    #2 reset = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_resp", "rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(0));
    check("rst_resp", "busy", 32'(busy), 32'(0));
    check("rst_resp", "SrcA", SrcA, 32'(0));
    check("rst_resp", "result", rsp0_result, 32'(0));
    check("rst_resp", "ready_in_reset", 32'(req1_ready), 32'(0));
    req1_valid = 1'b0;
    step();
    reset = 1'b0;
    model_prio = 0;
    for (int i = 0; i < 4; i++) begin
      rsp0_ready = 1'b1;
      step();
      check("rst_resp", "no_late_rsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
      check("rst_resp", "no_late_busy", 32'(busy), 32'(0));
    end
    rsp0_ready = 1'b0;

    // Reset during EXEC discards the operation as well
    drive_req(1, 1'b1, 32'd3, 32'd3, 3'd0);
    step();
    drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    #1 reset = 1'b1;
    #1;
    check("rst_exec", "busy", 32'(busy), 32'(0));
    step();
    reset = 1'b0;
    model_prio = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_exec", "no_late_rsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
    end

    // Both valid after reset: req0 first, then req1
    run_txn(1'b1, 32'hF0, 32'h3C, 3'd2, 1'b1, 32'hF0, 32'h3C, 3'd3, 0, "both_first");
    run_txn(1'b1, 32'hF0, 32'h3C, 3'd2, 1'b1, 32'hF0, 32'h3C, 3'd3, 0, "both_second");
    run_txn(1'b1, 32'h1, 32'h2, 3'd0, 1'b1, 32'h3, 32'h4, 3'd1, 1, "both_third");

    for (int it = 0; it < 40; it++) begin
      sel  = 2'($urandom_range(0, 3));
      ra0  = $urandom;
      rb0  = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      rop0 = 3'($urandom_range(0, 7));
      ra1  = $urandom;
      rb1  = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      rop1 = 3'($urandom_range(0, 7));
      if (sel == 2'b00) begin
        #1;
        check("rand_idle", "ready", 32'({req1_ready, req0_ready}), 32'(0));
        check("rand_idle", "busy", 32'(busy), 32'(0));
        step();
      end else begin
        run_txn(sel[0], ra0, rb0, rop0, sel[1], ra1, rb1, rop1, $urandom_range(0, 3), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
